ysyx_23060075_mem_arbiter: RTL
==============================

YSYX_23060075_MEM_ARBITER -- requirements
Module: ysyx_23060075_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of addresses and of read/write data.
REQ-002 Parameter MASK_WIDTH, default 4: byte-strobe width (DATA_WIDTH/8).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ifu_req_valid  input  1  fetch request; ifu_addr  input  DATA_WIDTH  fetch address.
REQ-006 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-007 ifu_resp_valid  output  1  fetch data valid; ifu_rdata  output  DATA_WIDTH  fetched word.
REQ-008 lsu_req_valid  input  1  load/store request; lsu_addr  input  DATA_WIDTH; lsu_wdata  input  DATA_WIDTH; lsu_wmask  input  MASK_WIDTH; lsu_wen  input  1 (1 = store).
REQ-009 lsu_req_ready  output  1  load/store request accepted this cycle.
REQ-010 lsu_resp_valid  output  1  load data / store ack valid; lsu_rdata  output  DATA_WIDTH  loaded word.
REQ-011 mem_req_valid  output  1; mem_addr, mem_wdata  output  DATA_WIDTH; mem_wmask  output  MASK_WIDTH; mem_wen  output  1: single downstream memory port.
REQ-012 mem_req_ready  input  1; mem_resp_valid  input  1; mem_rdata  input  DATA_WIDTH: memory handshake and response.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RESP; one outstanding transaction at most.
REQ-014 In IDLE, if any *_req_valid is high, the arbiter SHALL grant exactly one master, assert its *_req_ready combinationally that cycle, latch addr/wdata/wmask/wen (IFU: wen=0, wmask=0, wdata=0) and owner, and go to REQ.
REQ-015 *_req_ready SHALL be low in REQ and RESP; never both high.
REQ-016 In REQ, mem_req_valid SHALL be 1 with latched fields stable; on mem_req_ready=1, go to RESP.
REQ-017 In RESP, mem_req_valid SHALL be 0; on mem_resp_valid=1, owner's *_resp_valid SHALL equal 1 that same cycle (combinational), *_rdata = mem_rdata, state -> IDLE.
REQ-018 Non-owner *_resp_valid SHALL stay 0; *_rdata SHALL be mem_rdata regardless (only meaningful with resp_valid).
REQ-019 Stores SHALL also wait for mem_resp_valid (write ack); lsu_rdata content undefined then.
REQ-020 mem_resp_valid outside RESP SHALL be ignored (no resp_valid to any master).
REQ-021 Zero-wait memory (ready and resp immediate): accept cycle N, mem_req cycle N+1, response cycle N+2, next grant earliest N+3.
REQ-022 Simultaneous requests in IDLE resolved per REQ-027/028; loser keeps valid high and is served next IDLE.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, owner=IFU, last_grant=LSU, latched fields=0.
REQ-024 During and after reset all outputs *_req_ready, *_resp_valid, mem_req_valid SHALL be 0 until the first IDLE cycle with rst=0; mem_addr/wdata/wmask/wen = 0.
REQ-025 Reset mid-transaction SHALL abandon it; a later mem_resp_valid SHALL be ignored per REQ-020.

Configuration
REQ-026 Macro YSYX_23060075_ARB_RR_EN selects arbitration policy.
REQ-027 Undefined: fixed priority, LSU wins every tie.
REQ-028 Defined: round-robin; on tie the master not in last_grant wins; last_grant updates on each grant; first tie after reset goes to IFU.

Verification
REQ-029 Single fetch, ifu_addr=0x80000000, memory ready immediately, rdata=0x00000413 two cycles later -> ifu_req_ready cycle 0, mem_req_valid cycle 1 addr 0x80000000 wen 0, ifu_resp_valid=1 rdata 0x00000413 cycle 2, lsu_resp_valid=0 throughout.
REQ-030 Store lsu_addr=0x80001000 wdata=0xDEADBEEF wmask=0b1111 wen=1, mem_req_ready delayed 3 cycles -> mem fields held stable 4 cycles in REQ, lsu_resp_valid only on ack.
REQ-031 Both valid in IDLE, macro undefined, 3 back-to-back ties -> LSU granted all three; macro defined -> grants IFU, LSU, IFU.
REQ-032 Stray mem_resp_valid=1 in IDLE with rdata 0x12345678 -> no resp_valid, state stays IDLE.
REQ-033 rst=1 asserted while in RESP, then mem_resp_valid=1 after release -> no resp_valid; next request granted normally from IDLE.

Source files
------------

// File: rtl/ysyx_23060075_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port, one transaction in flight.
// Define YSYX_23060075_ARB_RR_EN for round-robin ties; otherwise LSU wins every tie.
module ysyx_23060075_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    input  logic [DATA_WIDTH-1:0] ifu_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_wmask,
    input  logic                  lsu_wen,
    output logic                  lsu_req_ready,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic                  mem_wen,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    state_t                state, state_nxt;
    owner_t                owner;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic                  wen_q;
    logic                  grant_ifu, grant_lsu, resp_fire;
`ifdef YSYX_23060075_ARB_RR_EN
    owner_t                last_grant;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
`ifdef YSYX_23060075_ARB_RR_EN
            last_grant <= OWN_LSU;
`endif
        end else begin
            state <= state_nxt;
            if (grant_lsu) begin
                owner   <= OWN_LSU;
                addr_q  <= lsu_addr;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
                wen_q   <= lsu_wen;
`ifdef YSYX_23060075_ARB_RR_EN
                last_grant <= OWN_LSU;
`endif
            end else if (grant_ifu) begin
                owner   <= OWN_IFU;
                addr_q  <= ifu_addr;
                wdata_q <= '0;
                wmask_q <= '0;
                wen_q   <= 1'b0;
`ifdef YSYX_23060075_ARB_RR_EN
                last_grant <= OWN_IFU;
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        resp_fire = 1'b0;
        // Every handshake output is masked by rst so nothing leaks while held in reset.
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (ifu_req_valid && lsu_req_valid) begin
`ifdef YSYX_23060075_ARB_RR_EN
                        if (last_grant == OWN_LSU) grant_ifu = 1'b1;
                        else                       grant_lsu = 1'b1;
`else
                        grant_lsu = 1'b1;
`endif
                    end else begin
                        grant_ifu = ifu_req_valid;
                        grant_lsu = lsu_req_valid;
                    end
                end
                if (grant_ifu || grant_lsu) state_nxt = REQ;
            end
            REQ:     if (mem_req_ready) state_nxt = RESP;
            RESP: begin
                resp_fire = mem_resp_valid && !rst;
                if (mem_resp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    assign lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;
    assign mem_req_valid  = (state == REQ) && !rst;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign mem_wen        = wen_q;

endmodule
